// File: rtl/life_sequencer.sv
// Generation sequencer for an 8x8 Life grid: load/run/pause/single-step control around an external evolve datapath.
// Optional build macro LIFE_STABLE_DETECT_EN: halt instead of advancing when the next generation equals the current one.
module life_sequencer #(
    parameter int unsigned TICK_DIV = 4,
    parameter int unsigned GEN_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             run,
    input  logic             step,
    input  logic [63:0]      seed,
    input  logic [63:0]      grid_next,
    output logic [63:0]      grid,
    output logic             advance,
    output logic [GEN_W-1:0] gen_count,
    output logic [1:0]       state,
    output logic             stable
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        HALT  = 2'b11
    } state_t;

    localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

    state_t           state_reg, state_next;
    logic [63:0]      grid_reg, grid_upd;
    logic [15:0]      tick_reg, tick_next;
    logic [GEN_W-1:0] gen_reg, gen_next;
    logic             step_prev_reg;
    logic             want_adv, adv, halt_go;

    always_comb begin
        state_next = state_reg;
        grid_upd   = grid_reg;
        tick_next  = tick_reg;
        gen_next   = gen_reg;
        want_adv   = 1'b0;
        adv        = 1'b0;
        halt_go    = 1'b0;

        case (state_reg)
            RUN: begin
                // Pausing freezes the tick phase so resume continues where it left off.
                if (!run) begin
                    state_next = PAUSE;
                end else if (tick_reg == TICK_LAST) begin
                    tick_next = '0;
                    want_adv  = 1'b1;
                end else begin
                    tick_next = tick_reg + 16'd1;
                end
            end
            PAUSE: begin
                if (run)
                    state_next = RUN;
                if (step && !step_prev_reg)
                    want_adv = 1'b1;
            end
            default: ;
        endcase

`ifdef LIFE_STABLE_DETECT_EN
        if (want_adv && ((grid_next == grid_reg) || (grid_reg == '0)))
            halt_go = 1'b1;
        else
            adv = want_adv;
`else
        adv = want_adv;
`endif

        if (adv) begin
            grid_upd = grid_next;
            gen_next = gen_reg + GEN_W'(1);
        end
        if (halt_go)
            state_next = HALT;

        if (load) begin
            state_next = run ? RUN : PAUSE;
            grid_upd   = seed;
            gen_next   = '0;
            tick_next  = '0;
            adv        = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            grid_reg      <= '0;
            tick_reg      <= '0;
            gen_reg       <= '0;
            step_prev_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            grid_reg      <= grid_upd;
            tick_reg      <= tick_next;
            gen_reg       <= gen_next;
            step_prev_reg <= step;
        end
    end

    assign grid      = grid_reg;
    assign gen_count = gen_reg;
    assign state     = state_reg;
    assign advance   = adv && !reset;

`ifdef LIFE_STABLE_DETECT_EN
    assign stable = (state_reg == HALT);
`else
    assign stable = 1'b0;
`endif

endmodule
